// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ready bus between the memory stage controller (master)
// and the data memory (slave).
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdy;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_rdy
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_rdy
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-access stage: issues data-memory requests, stalls upstream while busy,
// retires results toward writeback. Define MEM_ALIGN_CHK_EN to reject odd addresses.
//
// state | meaning
// IDLE  | no access outstanding; ALU results pass through in one cycle
// BUSY  | request held on the memory bus until mem_rdy or wait-limit abort
module mem_stage_ctrl #(
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    input  logic [15:0]       i_instruction,
    input  logic [DATA_W-1:0] i_data_out,
    input  logic [DATA_W-1:0] i_data_two,
    input  logic [2:0]        i_rd,
    input  logic              i_reg_write,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_mem_reg,
    input  logic              i_mem_en,
    output logic              o_stall,
    mem_stage_ctrl_if.master  mem_bus,
    output logic              o_wb_valid,
    output logic [15:0]       o_wb_instruction,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [2:0]        o_wb_reg,
    output logic              o_wb_write,
    output logic              o_timeout_err,
    output logic              o_align_err
);
    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [0:0] {IDLE, BUSY} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [2:0]        r_rd;
    logic              r_reg_write;
    logic              r_mem_reg;
    logic [15:0]       r_instruction;
    logic              r_wb_valid;
    logic [15:0]       r_wb_instruction;
    logic [DATA_W-1:0] r_wb_data;
    logic [2:0]        r_wb_reg;
    logic              r_wb_write;
    logic              r_timeout_err;
    logic              r_align_err;

    logic w_access;
    logic w_misalign;
    logic w_abort;

    assign w_access = i_in_valid & i_mem_en & (i_mem_read | i_mem_write);

`ifdef MEM_ALIGN_CHK_EN
    assign w_misalign = w_access & i_data_out[0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_abort = (r_count == LAST_CNT) & ~mem_bus.mem_rdy;
    assign o_stall = ((r_state == IDLE) & w_access & ~w_misalign)
                   | ((r_state == BUSY) & ~mem_bus.mem_rdy & ~w_abort);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_count          <= '0;
            r_mem_req        <= 1'b0;
            r_mem_we         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_wdata      <= '0;
            r_rd             <= '0;
            r_reg_write      <= 1'b0;
            r_mem_reg        <= 1'b0;
            r_instruction    <= '0;
            r_wb_valid       <= 1'b0;
            r_wb_instruction <= '0;
            r_wb_data        <= '0;
            r_wb_reg         <= '0;
            r_wb_write       <= 1'b0;
            r_timeout_err    <= 1'b0;
            r_align_err      <= 1'b0;
        end else begin
            r_wb_valid    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_align_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_misalign) begin
                        r_wb_valid       <= 1'b1;
                        r_wb_write       <= 1'b0;
                        r_wb_data        <= i_data_out;
                        r_wb_reg         <= i_rd;
                        r_wb_instruction <= i_instruction;
                        r_align_err      <= 1'b1;
                    end else if (w_access) begin
                        r_state       <= BUSY;
                        r_count       <= '0;
                        r_mem_req     <= 1'b1;
                        r_mem_we      <= i_mem_write;
                        r_mem_addr    <= i_data_out;
                        r_mem_wdata   <= i_data_two;
                        r_rd          <= i_rd;
                        r_reg_write   <= i_reg_write;
                        r_mem_reg     <= i_mem_reg;
                        r_instruction <= i_instruction;
                        r_wb_write    <= 1'b0;
                    end else if (i_in_valid) begin
                        r_wb_valid       <= 1'b1;
                        r_wb_data        <= i_data_out;
                        r_wb_reg         <= i_rd;
                        r_wb_write       <= i_reg_write;
                        r_wb_instruction <= i_instruction;
                    end else begin
                        r_wb_write <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_bus.mem_rdy) begin
                        r_state          <= IDLE;
                        r_mem_req        <= 1'b0;
                        r_mem_we         <= 1'b0;
                        r_wb_valid       <= 1'b1;
                        r_wb_reg         <= r_rd;
                        r_wb_write       <= r_reg_write;
                        r_wb_instruction <= r_instruction;
                        r_wb_data        <= (~r_mem_we & r_mem_reg) ? mem_bus.mem_rdata : r_mem_addr;
                    end else if (w_abort) begin
                        // Aborted access still retires so the slot is accounted for, but never writes
                        r_state          <= IDLE;
                        r_mem_req        <= 1'b0;
                        r_mem_we         <= 1'b0;
                        r_timeout_err    <= 1'b1;
                        r_wb_valid       <= 1'b1;
                        r_wb_write       <= 1'b0;
                        r_wb_reg         <= r_rd;
                        r_wb_instruction <= r_instruction;
                        r_wb_data        <= r_mem_addr;
                    end else begin
                        r_count <= (r_count == LAST_CNT) ? r_count : r_count + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_bus.mem_req   = r_mem_req;
    assign mem_bus.mem_we    = r_mem_we;
    assign mem_bus.mem_addr  = r_mem_addr;
    assign mem_bus.mem_wdata = r_mem_wdata;

    assign o_wb_valid       = r_wb_valid;
    assign o_wb_instruction = r_wb_instruction;
    assign o_wb_data        = r_wb_data;
    assign o_wb_reg         = r_wb_reg;
    assign o_wb_write       = r_wb_write;
    assign o_timeout_err    = r_timeout_err;
    assign o_align_err      = r_align_err;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: scenario tasks plus a writeback scoreboard.
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_in_valid, i_reg_write, i_mem_read, i_mem_write, i_mem_reg, i_mem_en;
    logic [15:0] i_instruction, i_data_out, i_data_two;
    logic [2:0]  i_rd;
    logic        o_stall, o_wb_valid, o_wb_write, o_timeout_err, o_align_err;
    logic [15:0] o_wb_instruction, o_wb_data;
    logic [2:0]  o_wb_reg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic        chk_data;
        logic [2:0]  rd;
        logic        wr;
        logic [15:0] instr;
        logic        terr;
        logic        aerr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mem_stage_ctrl_if #(.DATA_W(16)) mem_bus ();

    mem_stage_ctrl #(.DATA_W(16), .MAX_WAIT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_in_valid       (i_in_valid),
        .i_instruction    (i_instruction),
        .i_data_out       (i_data_out),
        .i_data_two       (i_data_two),
        .i_rd             (i_rd),
        .i_reg_write      (i_reg_write),
        .i_mem_read       (i_mem_read),
        .i_mem_write      (i_mem_write),
        .i_mem_reg        (i_mem_reg),
        .i_mem_en         (i_mem_en),
        .o_stall          (o_stall),
        .mem_bus          (mem_bus),
        .o_wb_valid       (o_wb_valid),
        .o_wb_instruction (o_wb_instruction),
        .o_wb_data        (o_wb_data),
        .o_wb_reg         (o_wb_reg),
        .o_wb_write       (o_wb_write),
        .o_timeout_err    (o_timeout_err),
        .o_align_err      (o_align_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    // Writeback scoreboard: every retirement must match the oldest expectation.
    always @(negedge clk) begin
        if (o_wb_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: wb_valid=1 instr=%h, required no retirement", o_wb_instruction);
            end else begin
                mon_e = sb.pop_front();
                if (o_wb_reg !== mon_e.rd || o_wb_write !== mon_e.wr || o_wb_instruction !== mon_e.instr
                    || o_timeout_err !== mon_e.terr || o_align_err !== mon_e.aerr
                    || (mon_e.chk_data && o_wb_data !== mon_e.data)) begin
                    errors++;
                    $display("FAIL wb_retire: got data=%h reg=%0d wr=%b instr=%h terr=%b aerr=%b, required data=%h reg=%0d wr=%b instr=%h terr=%b aerr=%b",
                             o_wb_data, o_wb_reg, o_wb_write, o_wb_instruction, o_timeout_err, o_align_err,
                             mon_e.data, mon_e.rd, mon_e.wr, mon_e.instr, mon_e.terr, mon_e.aerr);
                end
            end
        end else if (o_timeout_err !== 1'b0 || o_align_err !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL stray_pulse: terr=%b aerr=%b without wb_valid, required 0", o_timeout_err, o_align_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        i_in_valid = 0; i_instruction = '0; i_data_out = '0; i_data_two = '0; i_rd = '0;
        i_reg_write = 0; i_mem_read = 0; i_mem_write = 0; i_mem_reg = 0; i_mem_en = 0;
    endtask

    task automatic drive(input logic [15:0] instr, input logic [15:0] dout, input logic [15:0] dtwo,
                         input logic [2:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic mreg, input logic men);
        i_in_valid = 1; i_instruction = instr; i_data_out = dout; i_data_two = dtwo; i_rd = rd;
        i_reg_write = rw; i_mem_read = mr; i_mem_write = mw; i_mem_reg = mreg; i_mem_en = men;
    endtask

    task automatic test_reset();
        checks++;
        if (mem_bus.mem_req !== 0 || mem_bus.mem_we !== 0 || mem_bus.mem_addr !== 16'h0 || mem_bus.mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, required all 0",
                     mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata);
        end
        checks++;
        if (o_wb_valid !== 0 || o_wb_data !== 16'h0 || o_wb_reg !== 3'd0 || o_wb_write !== 0 || o_wb_instruction !== 16'h0) begin
            errors++;
            $display("FAIL reset_wb: valid=%b data=%h reg=%0d wr=%b instr=%h, required all 0",
                     o_wb_valid, o_wb_data, o_wb_reg, o_wb_write, o_wb_instruction);
        end
        checks++;
        if (o_stall !== 0 || o_timeout_err !== 0 || o_align_err !== 0) begin
            errors++;
            $display("FAIL reset_flags: stall=%b terr=%b aerr=%b, required 0", o_stall, o_timeout_err, o_align_err);
        end
        rst = 1;
    endtask

    task automatic test_passthrough();
        drive(16'h1111, 16'h1234, 16'h0, 3'd5, 1, 0, 0, 0, 0);
        sb.push_back('{16'h1234, 1'b1, 3'd5, 1'b1, 16'h1111, 1'b0, 1'b0});
        #1;
        checks++;
        if (o_stall !== 0) begin errors++; $display("FAIL alu_stall: stall=%b, required 0", o_stall); end
        tick();
        // Mem_en=0 must suppress the access even with Mem_read/Mem_write set
        drive(16'h1112, 16'h5678, 16'h9999, 3'd2, 0, 1, 1, 1, 0);
        sb.push_back('{16'h5678, 1'b1, 3'd2, 1'b0, 16'h1112, 1'b0, 1'b0});
        #1;
        checks++;
        if (o_stall !== 0) begin errors++; $display("FAIL men0_stall: stall=%b, required 0", o_stall); end
        tick();
        set_idle();
        checks++;
        if (mem_bus.mem_req !== 0) begin errors++; $display("FAIL men0_req: mem_req=%b, required 0", mem_bus.mem_req); end
        tick();
        checks++;
        if (o_wb_valid !== 0 || o_wb_write !== 0 || o_wb_data !== 16'h5678 || o_wb_reg !== 3'd2) begin
            errors++;
            $display("FAIL bubble_hold: valid=%b wr=%b data=%h reg=%0d, required 0 0 5678 2",
                     o_wb_valid, o_wb_write, o_wb_data, o_wb_reg);
        end
    endtask

    task automatic test_load();
        int stall_cyc = 0;
        drive(16'h2222, 16'h0040, 16'h0, 3'd3, 1, 1, 0, 1, 1);
        sb.push_back('{16'hBEEF, 1'b1, 3'd3, 1'b1, 16'h2222, 1'b0, 1'b0});
        #1; if (o_stall) stall_cyc++;
        tick();
        checks++;
        if (mem_bus.mem_req !== 1 || mem_bus.mem_we !== 0 || mem_bus.mem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL load_issue: req=%b we=%b addr=%h, required 1 0 0040", mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr);
        end
        #1; if (o_stall) stall_cyc++;
        tick();
        checks++;
        if (mem_bus.mem_req !== 1 || mem_bus.mem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL load_hold: req=%b addr=%h, required 1 0040", mem_bus.mem_req, mem_bus.mem_addr);
        end
        #1; if (o_stall) stall_cyc++;
        tick();
        mem_bus.mem_rdy = 1; mem_bus.mem_rdata = 16'hBEEF;
        set_idle();
        #1; if (o_stall) stall_cyc++;
        checks++;
        if (stall_cyc !== 3) begin errors++; $display("FAIL load_stall_cycles: got %0d, required 3", stall_cyc); end
        tick();
        mem_bus.mem_rdy = 0;
        checks++;
        if (mem_bus.mem_req !== 0) begin errors++; $display("FAIL load_done_req: mem_req=%b, required 0", mem_bus.mem_req); end
        tick();
    endtask

    task automatic test_store();
        // Mem_read and Mem_write together: write wins
        drive(16'h3333, 16'h0050, 16'h00AA, 3'd1, 0, 1, 1, 0, 1);
        sb.push_back('{16'h0050, 1'b1, 3'd1, 1'b0, 16'h3333, 1'b0, 1'b0});
        #1;
        checks++;
        if (o_stall !== 1) begin errors++; $display("FAIL store_stall_idle: stall=%b, required 1", o_stall); end
        tick();
        checks++;
        if (mem_bus.mem_req !== 1 || mem_bus.mem_we !== 1 || mem_bus.mem_wdata !== 16'h00AA) begin
            errors++;
            $display("FAIL store_issue: req=%b we=%b wdata=%h, required 1 1 00AA", mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_wdata);
        end
        mem_bus.mem_rdy = 1;
        set_idle();
        #1;
        checks++;
        if (o_stall !== 0) begin errors++; $display("FAIL store_stall_rdy: stall=%b, required 0", o_stall); end
        tick();
        mem_bus.mem_rdy = 0;
        checks++;
        if (mem_bus.mem_req !== 0 || mem_bus.mem_we !== 0) begin
            errors++;
            $display("FAIL store_done: req=%b we=%b, required 0 0", mem_bus.mem_req, mem_bus.mem_we);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(16'h5555, 16'h0080, 16'h0, 3'd6, 1, 1, 0, 1, 1);
        sb.push_back('{16'h1357, 1'b1, 3'd6, 1'b1, 16'h5555, 1'b0, 1'b0});
        tick();
        mem_bus.mem_rdy = 1; mem_bus.mem_rdata = 16'h1357;
        tick();
        mem_bus.mem_rdy = 0;
        drive(16'h6666, 16'h0090, 16'h0, 3'd7, 1, 1, 0, 0, 1);
        sb.push_back('{16'h0090, 1'b1, 3'd7, 1'b1, 16'h6666, 1'b0, 1'b0});
        #1;
        checks++;
        if (o_stall !== 1 || mem_bus.mem_req !== 0) begin
            errors++;
            $display("FAIL b2b_second_idle: stall=%b req=%b, required 1 0", o_stall, mem_bus.mem_req);
        end
        tick();
        checks++;
        if (mem_bus.mem_addr !== 16'h0090 || mem_bus.mem_req !== 1) begin
            errors++;
            $display("FAIL b2b_second_issue: addr=%h req=%b, required 0090 1", mem_bus.mem_addr, mem_bus.mem_req);
        end
        mem_bus.mem_rdy = 1; mem_bus.mem_rdata = 16'h2468;
        tick();
        mem_bus.mem_rdy = 0;
        set_idle();
        tick();
    endtask

    task automatic test_timeout();
        int nreq = 0;
        int nstall = 0;
        int nterr = 0;
        drive(16'h4444, 16'h0060, 16'h0, 3'd4, 1, 1, 0, 1, 1);
        sb.push_back('{16'h0060, 1'b0, 3'd4, 1'b0, 16'h4444, 1'b1, 1'b0});
        #1;
        checks++;
        if (o_stall !== 1) begin errors++; $display("FAIL timeout_stall_idle: stall=%b, required 1", o_stall); end
        tick();
        set_idle();
        for (int i = 0; i < 14; i++) begin
            #1;
            if (mem_bus.mem_req === 1'b1) begin
                nreq++;
                if (o_stall === 1'b1) nstall++;
            end
            if (o_timeout_err === 1'b1) nterr++;
            tick();
        end
        checks++;
        if (nreq !== 8) begin errors++; $display("FAIL timeout_req_cycles: got %0d, required 8", nreq); end
        checks++;
        if (nstall !== 7) begin errors++; $display("FAIL timeout_busy_stall: got %0d, required 7", nstall); end
        checks++;
        if (nterr !== 1) begin errors++; $display("FAIL timeout_pulses: got %0d, required 1", nterr); end
        checks++;
        if (o_stall !== 0) begin errors++; $display("FAIL timeout_stall_end: stall=%b, required 0", o_stall); end
    endtask

    task automatic test_align();
        drive(16'h7777, 16'h0041, 16'h0, 3'd2, 1, 1, 0, 1, 1);
`ifdef MEM_ALIGN_CHK_EN
        sb.push_back('{16'h0041, 1'b1, 3'd2, 1'b0, 16'h7777, 1'b0, 1'b1});
        #1;
        checks++;
        if (o_stall !== 0) begin errors++; $display("FAIL align_stall: stall=%b, required 0", o_stall); end
        tick();
        set_idle();
        checks++;
        if (mem_bus.mem_req !== 0 || o_align_err !== 1) begin
            errors++;
            $display("FAIL align_reject: req=%b aerr=%b, required 0 1", mem_bus.mem_req, o_align_err);
        end
        tick();
`else
        sb.push_back('{16'hCAFE, 1'b1, 3'd2, 1'b1, 16'h7777, 1'b0, 1'b0});
        #1;
        checks++;
        if (o_stall !== 1) begin errors++; $display("FAIL odd_stall: stall=%b, required 1", o_stall); end
        tick();
        checks++;
        if (mem_bus.mem_req !== 1 || mem_bus.mem_addr !== 16'h0041 || o_align_err !== 0) begin
            errors++;
            $display("FAIL odd_issue: req=%b addr=%h aerr=%b, required 1 0041 0", mem_bus.mem_req, mem_bus.mem_addr, o_align_err);
        end
        mem_bus.mem_rdy = 1; mem_bus.mem_rdata = 16'hCAFE;
        tick();
        mem_bus.mem_rdy = 0;
        set_idle();
        tick();
`endif
    endtask

    task automatic test_reset_mid_access();
        drive(16'h8888, 16'h0070, 16'h0, 3'd3, 1, 1, 0, 1, 1);
        tick();
        set_idle();
        checks++;
        if (mem_bus.mem_req !== 1) begin errors++; $display("FAIL rst_mid_busy: mem_req=%b, required 1", mem_bus.mem_req); end
        rst = 0;
        tick();
        rst = 1;
        #1;
        checks++;
        if (mem_bus.mem_req !== 0 || o_wb_valid !== 0 || o_stall !== 0) begin
            errors++;
            $display("FAIL rst_mid_clear: req=%b wb_valid=%b stall=%b, required 0 0 0", mem_bus.mem_req, o_wb_valid, o_stall);
        end
        mem_bus.mem_rdy = 1; mem_bus.mem_rdata = 16'hDEAD;
        tick();
        mem_bus.mem_rdy = 0;
        checks++;
        if (o_wb_valid !== 0) begin errors++; $display("FAIL rst_mid_late_rdy: wb_valid=%b, required 0", o_wb_valid); end
        tick();
    endtask

    initial begin
        set_idle();
        mem_bus.mem_rdy = 0;
        mem_bus.mem_rdata = '0;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        tick();
        test_passthrough();
        test_load();
        test_store();
        test_back_to_back();
        test_timeout();
        test_align();
        test_reset_mid_access();
        repeat (3) tick();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: %0d retirements outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
